exe_stage: RTL and testbench

//  Execute stage; consumes the 126-bit ID->EXE bus and produces the 108-bit EXE->MEM bus.

---
 rtl/exe_stage.sv | 196 +++++++++++++++++++
 tb/tb_exe_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage -- RV32IM execute stage.
//
// Registers the ID->EXE bus, then computes the ALU / multiplier result from
// that register. Integer multiplies finish in one cycle. Divides and
// remainders use an iterative restoring divider that holds upstream off
// through exe_stall_o.
//
// Ports
//   clk              clock, all state on posedge
//   rst_n            asynchronous active-low reset
//   id_exe_bus_in    [125:0] {op1,op2,rd,rd_wen,exe_fun[18:0],mem_we,mem_re,wb_sel,pc}
//   id_valid_in      id_exe_bus_in carries a real instruction
//   exe_flush_i      kill the instruction held in EXE and abort any divide
//   exe_stall_o      1 = EXE is not accepting a new instruction
//   exe_mem_bus_out  [107:0] {result,store_data,rd,rd_wen,mem_we,mem_re,wb_sel,pc,valid}
//
// Divider FSM
//   state      | meaning
//   S_IDLE     | no divide in flight; a non-special divide raises the stall
//   S_DIV_RUN  | one quotient bit per cycle, cnt_q counts 31 down to 0
//   S_DIV_DONE | signed quotient/remainder held in quo_q/rem_q, result valid

module exe_stage #(
  parameter int XLEN        = 32,
  parameter bit DIV_ZERO_FB = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [125:0] id_exe_bus_in,
  input  logic         id_valid_in,
  input  logic         exe_flush_i,
  output logic         exe_stall_o,
  output logic [107:0] exe_mem_bus_out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_RUN  = 2'd1,
    S_DIV_DONE = 2'd2
  } state_e;

  logic [125:0]    bus_q;
  logic            vld_q;
  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic            qneg_q;
  logic            rneg_q;

  // Fields of the registered bus
  logic [XLEN-1:0] op1, op2, pc;
  logic [4:0]      rd;
  logic            rd_wen, mem_we, mem_re;
  logic [18:0]     fun;
  logic [2:0]      wb_sel;

  assign op1    = bus_q[125:94];
  assign op2    = bus_q[93:62];
  assign rd     = bus_q[61:57];
  assign rd_wen = bus_q[56];
  assign fun    = bus_q[55:37];
  assign mem_we = bus_q[36];
  assign mem_re = bus_q[35];
  assign wb_sel = bus_q[34:32];
  assign pc     = bus_q[31:0];

  // Divide classification
  logic is_div, is_sdiv, is_quo;
  logic div_zero, div_ovf, div_special, div_start;
  logic [XLEN-1:0] spec_res;

  assign is_div   = |fun[17:14];
  assign is_sdiv  = fun[14] | fun[16];
  assign is_quo   = fun[14] | fun[15];
  assign div_zero = (op2 == 32'h0);
  assign div_ovf  = is_sdiv && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
  assign div_special = DIV_ZERO_FB && (div_zero || div_ovf);
  assign div_start   = (state_q == S_IDLE) && vld_q && is_div && !div_special;

  assign exe_stall_o = div_start || (state_q == S_DIV_RUN);

  always_comb begin
    spec_res = '0;
    if (div_zero) spec_res = is_quo ? 32'hFFFF_FFFF : op1;
    else          spec_res = is_quo ? 32'h8000_0000 : 32'h0;
  end

  // Operand magnitudes for the divider; unsigned ops take the operands as-is
  logic [XLEN-1:0] op1_abs, op2_abs;
  assign op1_abs = (is_sdiv && op1[31]) ? (~op1 + 32'd1) : op1;
  assign op2_abs = (is_sdiv && op2[31]) ? (~op2 + 32'd1) : op2;

  // One restoring step: shift the next dividend bit into the partial remainder
  logic [32:0]     div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub, rem_d, quo_d;

  assign div_shift = {rem_q, quo_q[31]};
  assign div_ge    = (div_shift >= {1'b0, dvs_q});
  assign div_sub   = div_shift[31:0] - dvs_q;
  assign rem_d     = div_ge ? div_sub : div_shift[31:0];
  assign quo_d     = {quo_q[30:0], div_ge};

  // Single 64-bit multiplier; operand extension selects the signedness
  logic [63:0] mul_a, mul_b, mul_p;
  assign mul_a = {{32{(fun[11] | fun[12]) & op1[31]}}, op1};
  assign mul_b = {{32{fun[11] & op2[31]}}, op2};
  assign mul_p = mul_a * mul_b;

  logic [XLEN-1:0] alu_res, result;
  logic [4:0]      shamt;
  assign shamt = op2[4:0];

  always_comb begin
    alu_res = '0;
    if      (fun[0])  alu_res = op1 + op2;
    else if (fun[1])  alu_res = op1 - op2;
    else if (fun[2])  alu_res = op1 & op2;
    else if (fun[3])  alu_res = op1 | op2;
    else if (fun[4])  alu_res = op1 ^ op2;
    else if (fun[5])  alu_res = op1 << shamt;
    else if (fun[6])  alu_res = op1 >> shamt;
    else if (fun[7])  alu_res = $unsigned($signed(op1) >>> shamt);
    else if (fun[8])  alu_res = {31'b0, $signed(op1) < $signed(op2)};
    else if (fun[9])  alu_res = {31'b0, op1 < op2};
    else if (fun[10]) alu_res = mul_p[31:0];
    else if (fun[11] | fun[12] | fun[13]) alu_res = mul_p[63:32];
    else if (fun[18]) alu_res = op1;
  end

  always_comb begin
    result = '0;
    if (state_q == S_DIV_DONE) result = is_quo ? quo_q : rem_q;
    else if (is_div)           result = div_special ? spec_res : 32'h0;
    else                       result = alu_res;
  end

  assign exe_mem_bus_out = {result, op2, rd, rd_wen, mem_we, mem_re, wb_sel, pc,
                            vld_q & ~exe_stall_o};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q   <= '0;
      vld_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      // A flush frees the stage this edge, so the upstream bus is taken too
      if (!exe_stall_o || exe_flush_i) bus_q <= id_exe_bus_in;

      if (exe_flush_i)       vld_q <= 1'b0;
      else if (!exe_stall_o) vld_q <= id_valid_in;

      if (exe_flush_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (div_start) begin
              quo_q   <= op1_abs;
              rem_q   <= '0;
              dvs_q   <= op2_abs;
              // A zero divisor yields all-ones regardless of sign
              qneg_q  <= is_sdiv && (op1[31] ^ op2[31]) && !div_zero;
              rneg_q  <= is_sdiv && op1[31];
              cnt_q   <= 5'd31;
              state_q <= S_DIV_RUN;
            end
          end
          S_DIV_RUN: begin
            if (cnt_q == 5'd0) begin
              quo_q   <= qneg_q ? (~quo_d + 32'd1) : quo_d;
              rem_q   <= rneg_q ? (~rem_d + 32'd1) : rem_d;
              state_q <= S_DIV_DONE;
            end else begin
              quo_q <= quo_d;
              rem_q <= rem_d;
              cnt_q <= cnt_q - 5'd1;
            end
          end
          S_DIV_DONE: state_q <= S_IDLE;
          default:    state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [125:0] bus_in;
  logic         valid_in;
  logic         flush;
  logic         stall;
  logic [107:0] bus_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage #(.XLEN(32), .DIV_ZERO_FB(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_exe_bus_in  (bus_in),
    .id_valid_in    (valid_in),
    .exe_flush_i    (flush),
    .exe_stall_o    (stall),
    .exe_mem_bus_out(bus_out)
  );

  logic [31:0] o_res, o_store, o_pc;
  logic [4:0]  o_rd;
  logic        o_valid;
  assign o_res   = bus_out[107:76];
  assign o_store = bus_out[75:44];
  assign o_rd    = bus_out[43:39];
  assign o_pc    = bus_out[32:1];
  assign o_valid = bus_out[0];

  localparam int F_ADD = 0, F_SUB = 1, F_AND = 2, F_OR = 3, F_XOR = 4, F_SLL = 5;
  localparam int F_SRL = 6, F_SRA = 7, F_SLT = 8, F_SLTU = 9, F_MUL = 10, F_MULH = 11;
  localparam int F_MULHSU = 12, F_MULHU = 13, F_DIV = 14, F_DIVU = 15, F_REM = 16;
  localparam int F_REMU = 17, F_COPY1 = 18, F_NONE = 19;

  function automatic logic [18:0] fn(input int b);
    logic [18:0] f;
    f = '0;
    if (b < 19) f[b] = 1'b1;
    return f;
  endfunction

  function automatic logic [125:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] rd, input int fb,
                                      input logic [31:0] pc);
    return {a, b, rd, 1'b1, fn(fb), 1'b0, 1'b0, 3'b001, pc};
  endfunction

  localparam int NV = 15;
  localparam int          V_F [NV] = '{F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA, F_SRA,
                                       F_SLT, F_SLTU, F_MUL, F_MULH, F_MULHSU, F_COPY1, F_NONE};
  localparam logic [31:0] V_A [NV] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                       32'd1, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                                       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                       32'hFFFFFFFF, 32'h12345678, 32'h12345678};
  localparam logic [31:0] V_B [NV] = '{32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                       32'd33, 32'd4, 32'd4, 32'd4,
                                       32'd1, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                                       32'hFFFFFFFF, 32'd0, 32'd1};
  localparam logic [31:0] V_E [NV] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                       32'd2, 32'h08000000, 32'hF8000000, 32'h07FFFFFF,
                                       32'd1, 32'd0, 32'd1, 32'h40000000,
                                       32'hFFFFFFFF, 32'h12345678, 32'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus_in   = mk(32'hFFFFFFFF, 32'd1, 5'd9, F_ADD, 32'h100);
    valid_in = 1'b1;
    step();
    step();
    checks++;
    if (bus_out !== 108'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0", bus_out);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    valid_in = 1'b0;
    rst_n    = 1'b1;
    step();
  endtask

  task automatic test_add();
    bus_in   = mk(32'hFFFFFFFF, 32'd1, 5'd9, F_ADD, 32'h100);
    valid_in = 1'b1;
    step();
    checks++;
    if (o_res !== 32'h0) begin
      errors++;
      $display("FAIL add_result: got %h expected 00000000", o_res);
    end
    checks++;
    if (o_rd !== 5'd9 || o_pc !== 32'h100) begin
      errors++;
      $display("FAIL add_passthru: got rd=%0d pc=%h expected rd=9 pc=00000100", o_rd, o_pc);
    end
    checks++;
    if (o_valid !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL add_valid: got valid=%b stall=%b expected valid=1 stall=0", o_valid, stall);
    end
    valid_in = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_valid_drop: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_alu_back_to_back();
    int bad_stall;
    bad_stall = 0;
    for (int i = 0; i < NV; i++) begin
      bus_in   = mk(V_A[i], V_B[i], 5'(i), V_F[i], 32'h200 + 32'(i * 4));
      valid_in = 1'b1;
      step();
      if (stall !== 1'b0) bad_stall++;
      checks++;
      if (o_res !== V_E[i] || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL alu_vec%0d: got result=%h valid=%b expected result=%h valid=1",
                 i, o_res, o_valid, V_E[i]);
      end
    end
    checks++;
    if (o_store !== 32'd1) begin
      errors++;
      $display("FAIL alu_store_data: got %h expected 00000001", o_store);
    end
    checks++;
    if (bad_stall != 0) begin
      errors++;
      $display("FAIL alu_stall: got %0d stalled cycles expected 0", bad_stall);
    end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_divu();
    int n, bad_v;
    bus_in   = mk(32'd100, 32'd7, 5'd4, F_DIVU, 32'h300);
    valid_in = 1'b1;
    step();
    n = 0; bad_v = 0;
    while (stall === 1'b1 && n < 60) begin
      if (o_valid !== 1'b0) bad_v++;
      n++;
      step();
    end
    checks++;
    if (n != 33 || bad_v != 0) begin
      errors++;
      $display("FAIL divu_stall: got %0d cycles (%0d valid) expected 33 (0)", n, bad_v);
    end
    checks++;
    if (o_res !== 32'd14 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL divu_result: got %h valid=%b expected 0000000e valid=1", o_res, o_valid);
    end
    // back-to-back: next op offered in the DONE cycle
    bus_in = mk(32'd100, 32'd7, 5'd5, F_REMU, 32'h304);
    step();
    n = 0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      step();
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL remu_stall: got %0d cycles expected 33", n);
    end
    checks++;
    if (o_res !== 32'd2 || o_valid !== 1'b1 || o_rd !== 5'd5) begin
      errors++;
      $display("FAIL remu_result: got %h valid=%b rd=%0d expected 00000002 valid=1 rd=5",
               o_res, o_valid, o_rd);
    end
    valid_in = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL divu_after: got valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_div_signed();
    int n;
    bus_in   = mk(32'hFFFFFFF9, 32'd2, 5'd6, F_DIV, 32'h400);
    valid_in = 1'b1;
    step();
    n = 0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      step();
    end
    checks++;
    if (n != 33 || o_res !== 32'hFFFFFFFD || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL div_neg: got %h after %0d cycles expected fffffffd after 33", o_res, n);
    end
    bus_in = mk(32'hFFFFFFF9, 32'd2, 5'd6, F_REM, 32'h404);
    step();
    n = 0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      step();
    end
    checks++;
    if (n != 33 || o_res !== 32'hFFFFFFFF || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rem_neg: got %h after %0d cycles expected ffffffff after 33", o_res, n);
    end
    bus_in = mk(32'h80000000, 32'hFFFFFFFF, 5'd7, F_DIV, 32'h408);
    step();
    checks++;
    if (stall !== 1'b0 || o_res !== 32'h80000000 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL div_ovf: got %h stall=%b valid=%b expected 80000000 stall=0 valid=1",
               o_res, stall, o_valid);
    end
    bus_in = mk(32'h80000000, 32'hFFFFFFFF, 5'd7, F_REM, 32'h40C);
    step();
    checks++;
    if (stall !== 1'b0 || o_res !== 32'h0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rem_ovf: got %h stall=%b expected 00000000 stall=0", o_res, stall);
    end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_div_zero();
    bus_in   = mk(32'd5, 32'd0, 5'd8, F_DIVU, 32'h500);
    valid_in = 1'b1;
    step();
    checks++;
    if (stall !== 1'b0 || o_res !== 32'hFFFFFFFF || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL divu_zero: got %h stall=%b valid=%b expected ffffffff stall=0 valid=1",
               o_res, stall, o_valid);
    end
    bus_in = mk(32'd5, 32'd0, 5'd8, F_REMU, 32'h504);
    step();
    checks++;
    if (stall !== 1'b0 || o_res !== 32'd5 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL remu_zero: got %h stall=%b expected 00000005 stall=0", o_res, stall);
    end
    bus_in = mk(32'hFFFFFFFB, 32'd0, 5'd8, F_DIV, 32'h508);
    step();
    checks++;
    if (stall !== 1'b0 || o_res !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_zero_neg: got %h stall=%b expected ffffffff stall=0", o_res, stall);
    end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_flush();
    bus_in   = mk(32'd1000, 32'd3, 5'd10, F_DIVU, 32'h600);
    valid_in = 1'b1;
    step();
    // queued instruction held upstream while the divide stalls
    bus_in = mk(32'd10, 32'd20, 5'd3, F_ADD, 32'h604);
    repeat (10) step();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_stall: got %b expected 1", stall);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got stall=%b valid=%b expected stall=0 valid=0", stall, o_valid);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_res !== 32'd30 || o_rd !== 5'd3) begin
      errors++;
      $display("FAIL flush_next_add: got %h valid=%b rd=%0d expected 0000001e valid=1 rd=3",
               o_res, o_valid, o_rd);
    end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_div();
    bus_in   = mk(32'd1000, 32'd3, 5'd11, F_DIVU, 32'h700);
    valid_in = 1'b1;
    step();
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_out !== 108'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: got bus=%h stall=%b expected 0 and 0", bus_out, stall);
    end
    valid_in = 1'b0;
    step();
    rst_n    = 1'b1;
    bus_in   = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, F_MULHU, 32'h800);
    valid_in = 1'b1;
    step();
    checks++;
    if (o_res !== 32'hFFFFFFFE || o_valid !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mulhu_after_reset: got %h valid=%b stall=%b expected fffffffe valid=1 stall=0",
               o_res, o_valid, stall);
    end
    valid_in = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_alu_back_to_back();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
